// File: rtl/cat_rec_pkg.sv
// cat_rec_pkg: state encoding and address/timing constants shared by the cat-recognizer scheduler.
package cat_rec_pkg;
    typedef enum logic [2:0] {IDLE, CLR, FETCH, DRAIN, BIAS, DECIDE, DONE} state_t;
    localparam int PIX_BASE = 1;
    localparam int W_BASE = 0;
    localparam int DRAIN_CYCLES = 2;
    localparam int RD_LAT = 1;
endpackage

// File: rtl/cat_rec_issue_pipe.sv
// cat_rec_issue_pipe: valid shift register turning bank read issues into capture and MAC strobes.
module cat_rec_issue_pipe
    import cat_rec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic flush,
    output logic cap_en,
    output logic mac_en
);
    logic [RD_LAT:0] v;
    always_ff @(posedge clk or negedge rst)
        if (!rst) v <= '0;
        else v <= flush ? '0 : {v[RD_LAT-1:0], issue};
    assign cap_en = v[RD_LAT-1];
    assign mac_en = v[RD_LAT];
endmodule

// File: rtl/cat_rec_scheduler.sv
// cat_rec_scheduler: sequences pixel/weight fetch, MAC, bias and sign decision for one inference.
// Define CAT_SCHED_BIAS_EN to include the BIAS step; otherwise DRAIN goes straight to DECIDE.
module cat_rec_scheduler
    import cat_rec_pkg::*;
#(
    parameter int Amba_Addr_Depth = 12,
    parameter int Rows = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     apb_req,
    input  logic                     acc_sign,
    output logic                     pix_rd,
    output logic [Amba_Addr_Depth:0] pix_addr,
    output logic                     w_rd,
    output logic [Amba_Addr_Depth:0] w_addr,
    output logic                     cap_en,
    output logic                     mac_en,
    output logic                     acc_clr,
    output logic                     bias_add,
    output logic                     busy,
    output logic                     done,
    output logic                     cat_out
);
    localparam int AW = Amba_Addr_Depth + 1;
    localparam int CW = $clog2(Rows) + 1;
    state_t state, next;
    logic [CW-1:0] row;
    logic [1:0] dcnt;
    logic issue, flush, last_drain;
    assign last_drain = dcnt == 2'(DRAIN_CYCLES - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE:   next = start ? CLR : IDLE;
            CLR:    next = FETCH;
            FETCH:  next = row == CW'(Rows) ? DRAIN : FETCH;
`ifdef CAT_SCHED_BIAS_EN
            DRAIN:  next = last_drain ? BIAS : DRAIN;
            BIAS:   next = DECIDE;
`else
            DRAIN:  next = last_drain ? DECIDE : DRAIN;
`endif
            DECIDE: next = DONE;
            DONE:   next = start ? DONE : IDLE;
            default: next = IDLE;
        endcase
        if (!start && state != DONE) next = IDLE;
    end
    // Outputs are registered decodes of the state being entered, so they line up with it.
    assign issue = next == FETCH && !apb_req;
    assign flush = next == IDLE || next == CLR;
    assign w_rd = pix_rd;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            row      <= '0;
            dcnt     <= '0;
            pix_rd   <= 1'b0;
            pix_addr <= '0;
            w_addr   <= '0;
            acc_clr  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cat_out  <= 1'b0;
        end else begin
            row     <= next == CLR ? '0 : row + CW'(issue);
            dcnt    <= state == DRAIN ? dcnt + 2'd1 : '0;
            pix_rd  <= issue;
            acc_clr <= next == CLR;
            busy    <= next != IDLE && next != DONE;
            done    <= next == DONE;
            if (issue) begin
                pix_addr <= AW'(row) + AW'(PIX_BASE);
                w_addr   <= AW'(row) + AW'(W_BASE);
            end
            if (state == DECIDE && next == DONE) cat_out <= ~acc_sign;
        end
`ifdef CAT_SCHED_BIAS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) bias_add <= 1'b0;
        else bias_add <= next == BIAS;
`else
    assign bias_add = 1'b0;
`endif
    cat_rec_issue_pipe u_pipe (
        .clk    (clk),
        .rst    (rst),
        .issue  (pix_rd),
        .flush  (flush),
        .cap_en (cap_en),
        .mac_en (mac_en)
    );
endmodule
